// File: rtl/multicycle_ctrl_unit.sv
`default_nettype none
// ============================================================================
// multicycle_ctrl_unit : FETCH/DECODE/EXEC/MEM/WB control FSM for a multicycle
//                        RV32-style datapath, with sticky illegal/timeout traps.
// Revision: 1.0
// ============================================================================
module multicycle_ctrl_unit #(
  parameter int SUPPORT_JAL = 1,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       instr_valid,
  input  logic       mem_ready,
  input  logic       br_taken,
  output logic       fetch_req,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic [1:0] alu_op,
  output logic       alu_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       branch,
  output logic       jump,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'b000,
    S_DECODE = 3'b001,
    S_EXEC   = 3'b010,
    S_MEM    = 3'b011,
    S_WB     = 3'b100,
    S_TRAP   = 3'b101
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_LOAD   = 3'd1,
    C_STORE  = 3'd2,
    C_R      = 3'd3,
    C_I      = 3'd4,
    C_BRANCH = 3'd5,
    C_JAL    = 3'd6
  } class_t;

  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  state_t     w_next;
  class_t     r_class;
  class_t     w_class;
  logic       w_legal;
  logic       w_f7_ok;
  logic [7:0] r_wait;
  logic       r_illegal;
  logic       r_timeout;

  assign w_f7_ok = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);

  // Instruction classification; only consumed while in DECODE.
  always_comb begin
    w_class = C_NONE;
    w_legal = 1'b0;
    case (opcode)
      c_OP_LOAD: begin
        w_class = C_LOAD;
        w_legal = 1'b1;
      end
      c_OP_STORE: begin
        w_class = C_STORE;
        w_legal = 1'b1;
      end
      c_OP_R: begin
        w_class = C_R;
        w_legal = w_f7_ok;
      end
      c_OP_I: begin
        w_class = C_I;
        w_legal = !(((funct3 == 3'b001) || (funct3 == 3'b101)) && !w_f7_ok);
      end
      c_OP_BRANCH: begin
        w_class = C_BRANCH;
        w_legal = (funct3 != 3'b010) && (funct3 != 3'b011);
      end
      c_OP_JAL: begin
        w_class = C_JAL;
        w_legal = (SUPPORT_JAL != 0);
      end
      default: begin
        w_class = C_NONE;
        w_legal = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Class register, MEM wait counter and sticky trap causes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_class   <= C_NONE;
      r_wait    <= 8'd0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == S_DECODE) begin
        r_class <= w_class;
        if (!w_legal) begin
          r_illegal <= 1'b1;
        end
      end
      if ((r_state == S_MEM) && (w_next == S_TRAP)) begin
        r_timeout <= 1'b1;
      end
      if (r_state != S_MEM) begin
        r_wait <= 8'd0;
      end else if (!mem_ready) begin
        r_wait <= r_wait + 8'd1;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    fetch_req  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_op     = 2'b00;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    branch     = 1'b0;
    jump       = 1'b0;

    case (r_state)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = w_legal ? S_EXEC : S_TRAP;
      end
      S_EXEC: begin
        case (r_class)
          C_LOAD, C_STORE: begin
            alu_src = 1'b1;
            w_next  = S_MEM;
          end
          C_R: begin
            alu_op = 2'b01;
            w_next = S_WB;
          end
          C_I: begin
            alu_op  = 2'b11;
            alu_src = 1'b1;
            w_next  = S_WB;
          end
          C_BRANCH: begin
            branch   = 1'b1;
            alu_op   = 2'b10;
            pc_write = br_taken;
            pc_src   = 1'b1;
            w_next   = S_FETCH;
          end
          C_JAL: begin
            jump      = 1'b1;
            reg_write = 1'b1;
            pc_write  = 1'b1;
            pc_src    = 1'b1;
            w_next    = S_FETCH;
          end
          default: w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_read  = (r_class == C_LOAD);
        mem_write = (r_class == C_STORE);
        // A ready in the last allowed cycle completes the access instead of trapping.
        if (mem_ready) begin
          w_next = (r_class == C_LOAD) ? S_WB : S_FETCH;
        end else if (r_wait == c_WAIT_LAST) begin
          w_next = S_TRAP;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_class == C_LOAD);
        w_next     = S_FETCH;
      end
      S_TRAP: begin
        w_next = S_TRAP;
      end
      default: w_next = S_FETCH;
    endcase

    // Every output is forced low while reset is held.
    if (rst) begin
      fetch_req  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      alu_op     = 2'b00;
      alu_src    = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      branch     = 1'b0;
      jump       = 1'b0;
    end
  end

  assign illegal = r_illegal && !rst;
  assign timeout = r_timeout && !rst;
  assign state   = rst ? 3'b000 : r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_unit.sv
`default_nettype none
// ============================================================================
// tb_multicycle_ctrl_unit : randomized scoreboard bench for two configurations
//                           (JAL legal / timeout 16, JAL illegal / timeout 3).
// Revision: 1.0
// ============================================================================
module tb_multicycle_ctrl_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       fetch_req;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       jump;
    logic       illegal;
    logic       timeout;
  } obs_t;

  localparam int K_ILL = 0, K_LOAD = 1, K_STORE = 2, K_R = 3, K_I = 4, K_BR = 5, K_JAL = 6;

  logic       clk = 1'b0;
  logic       rst0, rst1;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       instr_valid, mem_ready, br_taken;
  wire  [17:0] v0, v1;

  logic [17:0] q0[$];
  logic [17:0] q1[$];
  int          tests = 0;
  int          failed = 0;
  int          act = 0;
  logic        m_ill = 1'b0;
  logic        m_tmo = 1'b0;
  logic [17:0] me0, me1;

  always #5 clk = ~clk;

  multicycle_ctrl_unit #(.SUPPORT_JAL(1), .MEM_TIMEOUT(16)) dut0 (
    .clk(clk), .rst(rst0), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .br_taken(br_taken),
    .fetch_req(v0[14]), .ir_write(v0[13]), .pc_write(v0[12]), .pc_src(v0[11]),
    .alu_op(v0[10:9]), .alu_src(v0[8]), .mem_read(v0[7]), .mem_write(v0[6]),
    .mem_to_reg(v0[5]), .reg_write(v0[4]), .branch(v0[3]), .jump(v0[2]),
    .illegal(v0[1]), .timeout(v0[0]), .state(v0[17:15])
  );

  multicycle_ctrl_unit #(.SUPPORT_JAL(0), .MEM_TIMEOUT(3)) dut1 (
    .clk(clk), .rst(rst1), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .instr_valid(instr_valid), .mem_ready(mem_ready), .br_taken(br_taken),
    .fetch_req(v1[14]), .ir_write(v1[13]), .pc_write(v1[12]), .pc_src(v1[11]),
    .alu_op(v1[10:9]), .alu_src(v1[8]), .mem_read(v1[7]), .mem_write(v1[6]),
    .mem_to_reg(v1[5]), .reg_write(v1[4]), .branch(v1[3]), .jump(v1[2]),
    .illegal(v1[1]), .timeout(v1[0]), .state(v1[17:15])
  );

  // Monitor: one expected observation per cycle per DUT.
  always @(negedge clk) begin
    if (q0.size() > 0) begin
      me0 = q0.pop_front();
      tests++;
      if (v0 !== me0) begin
        failed++;
        $display("FAIL dut0_outputs t=%0t: got st=%b bus=%b, want st=%b bus=%b",
                 $time, v0[17:15], v0[14:0], me0[17:15], me0[14:0]);
      end
    end
    if (q1.size() > 0) begin
      me1 = q1.pop_front();
      tests++;
      if (v1 !== me1) begin
        failed++;
        $display("FAIL dut1_outputs t=%0t: got st=%b bus=%b, want st=%b bus=%b",
                 $time, v1[17:15], v1[14:0], me1[17:15], me1[14:0]);
      end
    end
  end

  function automatic obs_t blank(input logic [2:0] st);
    obs_t e;
    e    = '0;
    e.st = st;
    return e;
  endfunction

  function automatic int classify(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic jal_ok);
    logic f7_ok;
    f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
    if (opc == 7'b0000011) return K_LOAD;
    if (opc == 7'b0100011) return K_STORE;
    if (opc == 7'b0110011) return f7_ok ? K_R : K_ILL;
    if (opc == 7'b0010011) return ((f3 == 3'b001 || f3 == 3'b101) && !f7_ok) ? K_ILL : K_I;
    if (opc == 7'b1100011) return (f3 == 3'b010 || f3 == 3'b011) ? K_ILL : K_BR;
    if (opc == 7'b1101111) return jal_ok ? K_JAL : K_ILL;
    return K_ILL;
  endfunction

  // One clock cycle: expectation for the active DUT, the other sits in reset.
  task automatic cyc(input obs_t e, input logic all_reset);
    if (act == 0) begin
      q0.push_back(e);
      q1.push_back('0);
    end else begin
      q0.push_back('0);
      q1.push_back(e);
    end
    if (all_reset) begin
      q0[q0.size()-1] = '0;
      q1[q1.size()-1] = '0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    instr_valid = 1'($urandom);
    mem_ready   = 1'($urandom);
    br_taken    = 1'($urandom);
  endtask

  task automatic do_reset(input int n);
    rst0 = 1'b1;
    rst1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      junk();
      cyc('0, 1'b1);
    end
    rst0  = (act != 0);
    rst1  = (act != 1);
    m_ill = 1'b0;
    m_tmo = 1'b0;
  endtask

  task automatic trap_cycles(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      junk();
      e         = blank(3'b101);
      e.illegal = m_ill;
      e.timeout = m_tmo;
      cyc(e, 1'b0);
    end
  endtask

  task automatic do_instr(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input int wait_n, input int mem_n, input logic bt, input int rst_at);
    obs_t e;
    int   k;
    int   tmo;
    logic mr;
    tmo = (act == 0) ? 16 : 3;
    for (int i = 0; i < wait_n; i++) begin
      junk();
      instr_valid = 1'b0;
      opcode      = 7'($urandom);
      e           = blank(3'b000);
      e.fetch_req = 1'b1;
      cyc(e, 1'b0);
    end
    junk();
    instr_valid = 1'b1;
    opcode = opc;
    funct3 = f3;
    funct7 = f7;
    e = blank(3'b000);
    e.fetch_req = 1'b1;
    e.ir_write  = 1'b1;
    e.pc_write  = 1'b1;
    cyc(e, 1'b0);

    junk();
    cyc(blank(3'b001), 1'b0);
    k = classify(opc, f3, f7, act == 0);
    if (k == K_ILL) begin
      m_ill = 1'b1;
      trap_cycles(3);
      return;
    end

    junk();
    e = blank(3'b010);
    case (k)
      K_LOAD, K_STORE: e.alu_src = 1'b1;
      K_R: e.alu_op = 2'b01;
      K_I: begin e.alu_op = 2'b11; e.alu_src = 1'b1; end
      K_BR: begin
        br_taken   = bt;
        e.branch   = 1'b1;
        e.alu_op   = 2'b10;
        e.pc_write = bt;
        e.pc_src   = 1'b1;
      end
      default: begin
        e.jump      = 1'b1;
        e.reg_write = 1'b1;
        e.pc_write  = 1'b1;
        e.pc_src    = 1'b1;
      end
    endcase
    cyc(e, 1'b0);
    if (k == K_BR || k == K_JAL) return;

    if (k == K_LOAD || k == K_STORE) begin
      for (int i = 0; ; i++) begin
        if (i == rst_at) begin
          do_reset(2);
          return;
        end
        junk();
        mr          = (i == mem_n - 1);
        mem_ready   = mr;
        e           = blank(3'b011);
        e.mem_read  = (k == K_LOAD);
        e.mem_write = (k == K_STORE);
        cyc(e, 1'b0);
        if (mr) break;
        if (i == tmo - 1) begin
          m_tmo = 1'b1;
          trap_cycles(3);
          return;
        end
      end
      if (k == K_STORE) return;
    end

    junk();
    e            = blank(3'b100);
    e.reg_write  = 1'b1;
    e.mem_to_reg = (k == K_LOAD);
    cyc(e, 1'b0);
  endtask

  task automatic switch_to(input int a);
    act = a;
    do_reset(2);
  endtask

  task automatic random_instr();
    logic [6:0] opc, f7;
    logic [2:0] f3;
    int         sel, tmo, mem_n, rst_at;
    tmo = (act == 0) ? 16 : 3;
    sel = $urandom_range(0, 7);
    f3  = 3'($urandom);
    f7  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
    case (sel)
      0: opc = 7'b0000011;
      1: opc = 7'b0100011;
      2: opc = 7'b0110011;
      3: opc = 7'b0010011;
      4: opc = 7'b1100011;
      5: opc = 7'b1101111;
      6: opc = 7'($urandom);
      default: opc = 7'b0110011;
    endcase
    mem_n  = $urandom_range(1, tmo + 2);
    rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
    do_instr(opc, f3, f7, $urandom_range(0, 2), mem_n, 1'($urandom), rst_at);
    if (m_ill || m_tmo) do_reset($urandom_range(1, 2));
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    opcode = '0; funct3 = '0; funct7 = '0;
    instr_valid = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk);
    #1;
    switch_to(0);
    // R-type add, then load with ready on the third MEM cycle
    do_instr(7'b0110011, 3'b000, 7'h00, 0, 1, 1'b0, -1);
    do_instr(7'b0000011, 3'b010, 7'h00, 0, 3, 1'b0, -1);
    // Store that never completes: timeout after 16 MEM cycles
    do_instr(7'b0100011, 3'b010, 7'h00, 1, 40, 1'b0, -1);
    do_reset(2);
    // Branch taken / not taken, JAL, I-ALU shift
    do_instr(7'b1100011, 3'b000, 7'h00, 0, 1, 1'b1, -1);
    do_instr(7'b1100011, 3'b001, 7'h00, 0, 1, 1'b0, -1);
    do_instr(7'b1101111, 3'b000, 7'h00, 0, 1, 1'b0, -1);
    do_instr(7'b0010011, 3'b101, 7'h20, 0, 1, 1'b0, -1);
    // Ready on the final allowed MEM cycle wins
    do_instr(7'b0000011, 3'b010, 7'h00, 0, 16, 1'b0, -1);
    // Illegal R-type funct7
    do_instr(7'b0110011, 3'b000, 7'h01, 0, 1, 1'b0, -1);
    do_reset(1);
    // Reset during MEM of a load, then a clean fetch
    do_instr(7'b0000011, 3'b010, 7'h00, 0, 5, 1'b0, 1);
    do_instr(7'b0110011, 3'b000, 7'h00, 0, 1, 1'b0, -1);
    switch_to(1);
    // JAL illegal in the second configuration; short timeout boundaries
    do_instr(7'b1101111, 3'b000, 7'h00, 0, 1, 1'b0, -1);
    do_reset(1);
    do_instr(7'b0100011, 3'b000, 7'h00, 0, 3, 1'b0, -1);
    do_instr(7'b0100011, 3'b000, 7'h00, 0, 4, 1'b0, -1);
    do_reset(1);
    do_instr(7'b1100011, 3'b010, 7'h00, 0, 1, 1'b0, -1);
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) switch_to(1 - act);
      random_instr();
    end
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
